priority_ticket_queue: RTL and testbench
========================================

Name: priority_ticket_queue

Overview:
- Parametrised successor to the single-class client queue: issues ticket numbers to arriving clients, holds them in NUM_CLASSES per-priority FIFOs, and serves one ticket per Done pulse.
- Adds synchronous clocking, priority classes, per-class full flags, reject reporting and anti-starvation aging.
- Sits between the client-arrival front end (New) and the service-counter logic (Done).

Parameters:
- NUM_CLASSES, 2, number of priority classes; class 0 is highest priority.
- DEPTH, 100, ticket slots per class FIFO.
- TW, 8, ticket number width.
- STARVE_LIMIT, 4, consecutive bypasses of a waiting lower class before it is forced; 0 disables aging.
- Derived: CW = max(1, clog2(NUM_CLASSES)); NW = clog2(NUM_CLASSES*DEPTH+1).

Ports:
- Clk  in  1  rising-edge clock
- Reset_N  in  1  asynchronous, active-low reset
- New  in  1  one-cycle enqueue request
- New_Class  in  CW  class of the arriving client; sampled with New
- Done  in  1  one-cycle request to serve the next client
- Ticket  out  TW  ticket issued to the last accepted New
- Reject  out  1  one-cycle pulse: last New was refused
- Current_Client  out  TW  ticket now being served; 0 = none
- Current_Class  out  CW  class of Current_Client
- Serving  out  1  Current_Client is valid
- Total_Clients  out  NW  tickets waiting across all classes
- Full  out  NUM_CLASSES  per-class full flags
- Empty  out  1  Total_Clients == 0

Behaviour:
- Reset: asserting Reset_N low clears everything immediately, regardless of Clk.
  - Ticket = 0, Reject = 0, Current_Client = 0, Current_Class = 0, Serving = 0, Total_Clients = 0, Full = 0, Empty = 1.
  - All FIFO pointers and the aging counter are cleared, and the next ticket number is set to 1.
  - Reset mid-operation discards every waiting ticket.
- Ticket numbering:
  - A global counter starts at 1 and increments on each accepted New.
  - It wraps from 2^TW-1 to 1; 0 is never issued.
- Enqueue:
  - If New=1 and class New_Class is not full, the ticket is written to that class FIFO. At the next edge, Ticket = the issued number and Total_Clients increments.
  - If New=1 and the class is full, nothing is stored. Reject pulses for one cycle, and Ticket and the counter hold.
  - If New_Class >= NUM_CLASSES, the New is rejected.
  - Full and Reject are evaluated on pre-edge state.
- Serve:
  - On Done=1, the arbiter uses pre-edge occupancy to pick a class, pops that class's head, and registers it into Current_Client and Current_Class, with Serving = 1.
  - Latency is 1 cycle from Done to the Current_Client update.
  - If Done=1 and the queue is empty pre-edge: Current_Client = 0 and Serving = 0. This is not an error.
  - Without Done, Current_Client holds.
- Arbitration:
  - Default: the lowest-index non-empty class wins.
  - Aging counter (clog2(STARVE_LIMIT+1) bits):
    - Increments on each serve where some higher-index non-empty class was bypassed.
    - Resets to 0 on a serve with no bypass.
    - When it equals STARVE_LIMIT, the next serve instead takes the highest-index non-empty class, and the counter is reset.
- Simultaneous New and Done:
  - Both take effect in the same cycle.
  - Total_Clients net change = (+1 if accepted) + (-1 if popped).
  - A ticket enqueued this cycle is not servable this cycle, since the empty check uses pre-edge state.
  - New into a full class is rejected even if Done pops that class in the same cycle.
- Flags are registered and consistent with the FIFO state after each edge.
  - Full[c] = 1 when class c holds DEPTH tickets.
  - Empty = 1 when Total_Clients = 0.
- FIFO pointers wrap modulo DEPTH; DEPTH need not be a power of 2.

Test Plan (NUM_CLASSES=2, DEPTH=4, TW=8, STARVE_LIMIT=2 unless noted):
- Reset, then 4 New on class 1 → Ticket 1,2,3,4; Total_Clients=4; Full=2'b10; 5th New → Reject=1, Ticket stays 4, Total_Clients stays 4.
- Enqueue class1: 1,2; class0: 3,4; then 4 Done → Current_Client 3,4,1,2 with Current_Class 0,0,1,1; 5th Done → Current_Client=0, Serving=0, Empty=1.
- Aging: class1 holds 1; class0 holds 2,3,4,5; Done ×3 → Current_Client 2,3,1 (class1 forced after 2 bypasses); next Done → 4.
- Simultaneous: empty queue, New+Done in the same cycle → Current_Client=0, Total_Clients=1; next Done → Current_Client=1.
- Wrap (TW=3, DEPTH=8): 9 accepted New with Done interleaved so no class fills → tickets 1..7, then 1, 2; ticket 0 is never seen.
- Reset_N driven low between clock edges with 3 tickets waiting and Serving=1 → all outputs take their reset values immediately; the next New issues ticket 1.

Source files
------------

// File: rtl/priority_ticket_queue.sv
// Multi-class ticket queue: issues ticket numbers on New, buffers them in per-class FIFOs,
// and serves one ticket per Done using lowest-class-first priority with anti-starvation aging.
module priority_ticket_queue #(
    parameter int NUM_CLASSES  = 2,
    parameter int DEPTH        = 100,
    parameter int TW           = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    parameter int NW           = $clog2(NUM_CLASSES * DEPTH + 1)
) (
    input  logic                   Clk,
    input  logic                   Reset_N,
    input  logic                   New,
    input  logic [CW-1:0]          New_Class,
    input  logic                   Done,
    output logic [TW-1:0]          Ticket,
    output logic                   Reject,
    output logic [TW-1:0]          Current_Client,
    output logic [CW-1:0]          Current_Class,
    output logic                   Serving,
    output logic [NW-1:0]          Total_Clients,
    output logic [NUM_CLASSES-1:0] Full,
    output logic                   Empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int AW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [TW-1:0] TKT_MAX = '1;

    logic [TW-1:0]   mem_q    [NUM_CLASSES][DEPTH];
    logic [PW-1:0]   wr_ptr_q [NUM_CLASSES];
    logic [PW-1:0]   rd_ptr_q [NUM_CLASSES];
    logic [CNTW-1:0] cnt_q    [NUM_CLASSES];

    logic [TW-1:0] ticket_q, next_tkt_q, next_tkt_d, cur_client_q, head_tkt;
    logic [CW-1:0] cur_class_q, lo_sel, hi_sel, sel;
    logic [NW-1:0] total_q;
    logic [AW-1:0] age_q, age_d;
    logic          reject_q, serving_q, accept, pop, force_old;
    logic [NUM_CLASSES-1:0] full_vec, nonempty, cls_hit, pop_hit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        full_vec = '0;
        nonempty = '0;
        cls_hit  = '0;
        pop_hit  = '0;
        lo_sel   = '0;
        hi_sel   = '0;
        head_tkt = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            full_vec[c] = (cnt_q[c] == CNTW'(DEPTH));
            nonempty[c] = (cnt_q[c] != '0);
            cls_hit[c]  = (New_Class == CW'(c));
        end
        for (int c = NUM_CLASSES - 1; c >= 0; c--)
            if (nonempty[c]) lo_sel = CW'(c);
        for (int c = 0; c < NUM_CLASSES; c++)
            if (nonempty[c]) hi_sel = CW'(c);

        // Out-of-range classes match no cls_hit bit and are therefore refused.
        accept    = New && (|cls_hit) && !(|(cls_hit & full_vec));
        pop       = Done && (|nonempty);
        force_old = (STARVE_LIMIT != 0) && (age_q == AW'(STARVE_LIMIT));
        sel       = force_old ? hi_sel : lo_sel;

        for (int c = 0; c < NUM_CLASSES; c++) begin
            pop_hit[c] = pop && (sel == CW'(c));
            if (sel == CW'(c)) head_tkt = mem_q[c][rd_ptr_q[c]];
        end

        // A bypass happened when some non-empty class sits above the lowest one.
        age_d = age_q;
        if (pop) begin
            if (STARVE_LIMIT == 0 || force_old || hi_sel == lo_sel) age_d = '0;
            else                                                    age_d = age_q + AW'(1);
        end

        next_tkt_d = (next_tkt_q == TKT_MAX) ? TW'(1) : next_tkt_q + TW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            ticket_q     <= '0;
            reject_q     <= 1'b0;
            cur_client_q <= '0;
            cur_class_q  <= '0;
            serving_q    <= 1'b0;
            total_q      <= '0;
            next_tkt_q   <= TW'(1);
            age_q        <= '0;
            wr_ptr_q     <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            cnt_q        <= '{default: '0};
        end else begin
            reject_q <= New && !accept;
            if (accept) begin
                ticket_q   <= next_tkt_q;
                next_tkt_q <= next_tkt_d;
            end
            if (Done) begin
                cur_client_q <= pop ? head_tkt : '0;
                cur_class_q  <= pop ? sel : '0;
                serving_q    <= pop;
            end
            age_q   <= age_d;
            total_q <= total_q + NW'(accept) - NW'(pop);
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (accept && cls_hit[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
                if (pop_hit[c])           rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
                cnt_q[c] <= cnt_q[c] + CNTW'(accept && cls_hit[c]) - CNTW'(pop_hit[c]);
            end
        end
    end

    // NOTE: ticket storage is not reset; the pointers and counts alone define validity.
    always_ff @(posedge Clk) begin
        for (int c = 0; c < NUM_CLASSES; c++)
            if (accept && cls_hit[c]) mem_q[c][wr_ptr_q[c]] <= next_tkt_q;
    end

    assign Ticket         = ticket_q;
    assign Reject         = reject_q;
    assign Current_Client = cur_client_q;
    assign Current_Class  = cur_class_q;
    assign Serving        = serving_q;
    assign Total_Clients  = total_q;
    assign Full           = full_vec;
    assign Empty          = (total_q == '0);

endmodule

// File: tb/tb_priority_ticket_queue.sv
// Directed self-checking bench for priority_ticket_queue: a DEPTH=4/TW=8 instance for the
// main scenarios and a DEPTH=8/TW=3 instance for ticket-number wrap.
module tb_priority_ticket_queue;

    logic       Clk = 1'b0;
    logic       Reset_N = 1'b0;

    logic       New = 1'b0, Done = 1'b0;
    logic [0:0] New_Class = '0;
    logic [7:0] Ticket, Current_Client;
    logic       Reject, Serving, Empty;
    logic [0:0] Current_Class;
    logic [3:0] Total_Clients;
    logic [1:0] Full;

    logic       New_w = 1'b0, Done_w = 1'b0;
    logic [0:0] New_Class_w = '0;
    logic [2:0] Ticket_w, Current_Client_w;
    logic       Reject_w, Serving_w, Empty_w;
    logic [0:0] Current_Class_w;
    logic [4:0] Total_Clients_w;
    logic [1:0] Full_w;

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    priority_ticket_queue #(.NUM_CLASSES(2), .DEPTH(4), .TW(8), .STARVE_LIMIT(2)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .New(New), .New_Class(New_Class), .Done(Done),
        .Ticket(Ticket), .Reject(Reject), .Current_Client(Current_Client),
        .Current_Class(Current_Class), .Serving(Serving), .Total_Clients(Total_Clients),
        .Full(Full), .Empty(Empty)
    );

    priority_ticket_queue #(.NUM_CLASSES(2), .DEPTH(8), .TW(3), .STARVE_LIMIT(2)) dut_w (
        .Clk(Clk), .Reset_N(Reset_N), .New(New_w), .New_Class(New_Class_w), .Done(Done_w),
        .Ticket(Ticket_w), .Reject(Reject_w), .Current_Client(Current_Client_w),
        .Current_Class(Current_Class_w), .Serving(Serving_w), .Total_Clients(Total_Clients_w),
        .Full(Full_w), .Empty(Empty_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drives one cycle of stimulus; returns 1 time unit after the edge so outputs are settled.
    task automatic step(input logic n, input logic cls, input logic d);
        New = n; New_Class = cls; Done = d;
        @(posedge Clk); #1;
        New = 1'b0; Done = 1'b0;
    endtask

    task automatic step_w(input logic n, input logic cls, input logic d);
        New_w = n; New_Class_w = cls; Done_w = d;
        @(posedge Clk); #1;
        New_w = 1'b0; Done_w = 1'b0;
    endtask

    // Pulses reset between clock edges.
    task automatic pulse_reset();
        #2 Reset_N = 1'b0;
        #3 Reset_N = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ticket"},  32'(Ticket), 0);
        check({tag, " reject"},  32'(Reject), 0);
        check({tag, " client"},  32'(Current_Client), 0);
        check({tag, " class"},   32'(Current_Class), 0);
        check({tag, " serving"}, 32'(Serving), 0);
        check({tag, " total"},   32'(Total_Clients), 0);
        check({tag, " full"},    32'(Full), 0);
        check({tag, " empty"},   32'(Empty), 1);
    endtask

    logic [7:0] exp_serve [4];
    logic       exp_cls   [4];
    logic [2:0] exp_wrap  [9];

    initial begin
        // Reset state
        #3;
        check_reset_state("rst");
        #9 Reset_N = 1'b1;

        // Fill class 1, then overflow
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("fill ticket%0d", i), 32'(Ticket), 32'(i));
        end
        check("fill total", 32'(Total_Clients), 4);
        check("fill full",  32'(Full), 2);
        check("fill empty", 32'(Empty), 0);
        step(1'b1, 1'b1, 1'b0);
        check("ovf reject", 32'(Reject), 1);
        check("ovf ticket", 32'(Ticket), 4);
        check("ovf total",  32'(Total_Clients), 4);
        // New into full class with a same-cycle pop of that class is still refused
        step(1'b1, 1'b1, 1'b1);
        check("fullpop reject", 32'(Reject), 1);
        check("fullpop client", 32'(Current_Client), 1);
        check("fullpop class",  32'(Current_Class), 1);
        check("fullpop total",  32'(Total_Clients), 3);
        check("fullpop ticket", 32'(Ticket), 4);
        step(1'b0, 1'b0, 1'b0);
        check("reject clears", 32'(Reject), 0);

        // Priority order
        pulse_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        exp_serve = '{8'd3, 8'd4, 8'd1, 8'd2};
        exp_cls   = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("prio client%0d", i), 32'(Current_Client), 32'(exp_serve[i]));
            check($sformatf("prio class%0d", i),  32'(Current_Class), 32'(exp_cls[i]));
            check($sformatf("prio serving%0d", i), 32'(Serving), 1);
        end
        step(1'b0, 1'b0, 1'b1);
        check("drained client",  32'(Current_Client), 0);
        check("drained serving", 32'(Serving), 0);
        check("drained empty",   32'(Empty), 1);

        // Aging: class 1 forced after two bypasses
        pulse_reset();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        exp_serve = '{8'd2, 8'd3, 8'd1, 8'd4};
        exp_cls   = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("age client%0d", i), 32'(Current_Client), 32'(exp_serve[i]));
            check($sformatf("age class%0d", i),  32'(Current_Class), 32'(exp_cls[i]));
        end
        check("age total", 32'(Total_Clients), 1);

        // Simultaneous New and Done on an empty queue
        pulse_reset();
        step(1'b1, 1'b0, 1'b1);
        check("simul client",  32'(Current_Client), 0);
        check("simul serving", 32'(Serving), 0);
        check("simul total",   32'(Total_Clients), 1);
        check("simul ticket",  32'(Ticket), 1);
        step(1'b0, 1'b0, 1'b1);
        check("simul next client", 32'(Current_Client), 1);
        check("simul next total",  32'(Total_Clients), 0);

        // Asynchronous reset mid-operation
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("pre-rst serving", 32'(Serving), 1);
        check("pre-rst total",   32'(Total_Clients), 3);
        #2 Reset_N = 1'b0;
        #1;
        check_reset_state("async rst");
        #3 Reset_N = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check("post-rst ticket", 32'(Ticket), 1);
        check("post-rst total",  32'(Total_Clients), 1);

        // Ticket wrap on the 3-bit instance
        pulse_reset();
        exp_wrap = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        for (int i = 0; i < 9; i++) begin
            step_w(1'b1, 1'(i % 2), 1'b0);
            check($sformatf("wrap ticket%0d", i), 32'(Ticket_w), 32'(exp_wrap[i]));
            step_w(1'b0, 1'b0, 1'b1);
            check($sformatf("wrap serve%0d", i), 32'(Current_Client_w), 32'(exp_wrap[i]));
        end
        check("wrap empty", 32'(Empty_w), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
